gpr_wb_ctrl: RTL and testbench

Write-side controller for the 32×32 general-purpose register file. It merges single-cycle pipeline writebacks with long-latency writebacks from load/mul-div units, which arrive through a valid/ready queue. It drives the register file's single write port and publishes a per-register busy scoreboard to the issue stage. It also raises a stall request when queued results are starved by back-to-back pipeline writes.

---
 rtl/gpr_wb_pkg.sv | 28 ++
 rtl/gpr_wb_fifo.sv | 87 ++++++++
 rtl/gpr_wb_ctrl.sv | 161 ++++++++++++++++
 tb/tb_gpr_wb_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpr_wb_pkg
// Description : Shared types and constants for the GPR writeback controller.
// Revision    : 1.0 - initial release
// ============================================================================
package gpr_wb_pkg;

    // Native data width of the register file this controller serves
    localparam int WB_XLEN = 32;

    // Architectural zero register; writes to it are discarded
    localparam logic [4:0] REG_X0 = 5'd0;

    // One pending writeback: destination register and result
    typedef struct packed {
        logic [4:0]         addr;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

    // Starvation monitor states
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STARVE = 1'b1
    } wb_state_t;

endpackage : gpr_wb_pkg
`default_nettype wire

// File: rtl/gpr_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gpr_wb_fifo
// Description : DEPTH-entry circular buffer for long-latency writebacks with
//               an occupancy count and a per-entry valid/addr view used to
//               build the busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_wb_fifo
    import gpr_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [4:0]      push_addr,
    input  logic [XLEN-1:0] push_data,
    input  logic            pop,
    output logic [4:0]      head_addr,
    output logic [XLEN-1:0] head_data,
    output logic [CW-1:0]   count,
    output logic            entry_valid [DEPTH],
    output logic [4:0]      entry_addr  [DEPTH]
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [4:0]      addr_mem [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic            valid_q  [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Never overrun a full buffer or underrun an empty one
    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop  && (count != '0);

    // Pointers, occupancy and per-entry valid flags; reset empties the buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr          <= wr_ptr + PW'(1);
                valid_q[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr          <= rd_ptr + PW'(1);
                valid_q[rd_ptr] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage; contents are qualified by valid_q, so no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_view
            assign entry_valid[g] = valid_q[g];
            assign entry_addr[g]  = addr_mem[g];
        end
    endgenerate

endmodule : gpr_wb_fifo
`default_nettype wire

// File: rtl/gpr_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gpr_wb_ctrl
// Description : Write-side controller for the 32x32 GPR file. Merges
//               pipeline writebacks (highest priority) with queued
//               long-latency writebacks, drives the single registered write
//               port, publishes a busy scoreboard and requests a pipeline
//               stall when queued results are starved.
//               Optional feature macro: GPR_WB_FWD_EN (write-port bypass).
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_wb_ctrl
    import gpr_wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pipe_wb_en,
    input  logic [4:0]      pipe_wb_addr,
    input  logic [XLEN-1:0] pipe_wb_data,
    input  logic            lq_valid,
    output logic            lq_ready,
    input  logic [4:0]      lq_addr,
    input  logic [XLEN-1:0] lq_data,
    output logic            rf_wrt_en,
    output logic [4:0]      rf_wrt_addr,
    output logic [XLEN-1:0] rf_wrt_data,
    output logic [31:0]     busy,
    output logic            wb_stall_req
`ifdef GPR_WB_FWD_EN
   ,input  logic [4:0]      rd_addr1,
    input  logic [4:0]      rd_addr2,
    input  logic [XLEN-1:0] rf_rd_data1,
    input  logic [XLEN-1:0] rf_rd_data2,
    output logic [XLEN-1:0] fwd_data1,
    output logic [XLEN-1:0] fwd_data2
`endif
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int SCW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]  FULL_CNT   = CW'(DEPTH);
    localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

    logic            pipe_eff;
    logic            q_push;
    logic            q_pop;
    logic            q_nonempty;
    logic [4:0]      head_addr;
    logic [XLEN-1:0] head_data;
    logic [CW-1:0]   count;
    logic            entry_valid [DEPTH];
    logic [4:0]      entry_addr  [DEPTH];
    logic [SCW-1:0]  starve_cnt;
    wb_state_t       state;
    wb_state_t       state_nx;

    assign pipe_eff   = pipe_wb_en && (pipe_wb_addr != REG_X0);
    assign q_nonempty = (count != '0);
    // Ready looks only at the registered count, so a full queue never accepts
    assign lq_ready   = !reset && (count != FULL_CNT);
    // x0 transfers are acknowledged but never stored
    assign q_push     = lq_valid && lq_ready && (lq_addr != REG_X0);
    // Queue only drains when the pipeline has no effective write
    assign q_pop      = !pipe_eff && q_nonempty;

    gpr_wb_fifo #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (q_push),
        .push_addr   (lq_addr),
        .push_data   (lq_data),
        .pop         (q_pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    // Registered write port: pipeline first, then queue head, else idle/hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_wrt_en   <= 1'b0;
            rf_wrt_addr <= REG_X0;
            rf_wrt_data <= '0;
        end else if (pipe_eff) begin
            rf_wrt_en   <= 1'b1;
            rf_wrt_addr <= pipe_wb_addr;
            rf_wrt_data <= pipe_wb_data;
        end else if (q_nonempty) begin
            rf_wrt_en   <= 1'b1;
            rf_wrt_addr <= head_addr;
            rf_wrt_data <= head_data;
        end else begin
            rf_wrt_en   <= 1'b0;
        end
    end

    // Scoreboard: every queued destination plus the one in the output stage
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) busy[entry_addr[i]] = 1'b1;
        end
        if (rf_wrt_en) busy[rf_wrt_addr] = 1'b1;
        busy[0] = 1'b0;
    end

    // Count consecutive cycles the queue head loses to the pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (q_pop || !q_nonempty) begin
            starve_cnt <= '0;
        end else if (pipe_eff && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + SCW'(1);
        end
    end

    // Starvation FSM state and registered stall request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wb_stall_req <= 1'b0;
        end else begin
            state        <= state_nx;
            wb_stall_req <= (state_nx == STARVE);
        end
    end

    // Next state: enter STARVE at the limit unless the head drains this cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if ((starve_cnt == STARVE_LIM) && !q_pop) state_nx = STARVE;
            STARVE:  if (q_pop) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef GPR_WB_FWD_EN
    // Bypass the in-flight write to same-cycle register-file reads
    always_comb begin
        fwd_data1 = rf_rd_data1;
        fwd_data2 = rf_rd_data2;
        if (rf_wrt_en && (rd_addr1 != REG_X0) && (rf_wrt_addr == rd_addr1))
            fwd_data1 = rf_wrt_data;
        if (rf_wrt_en && (rd_addr2 != REG_X0) && (rf_wrt_addr == rd_addr2))
            fwd_data2 = rf_wrt_data;
    end
`endif

endmodule : gpr_wb_ctrl
`default_nettype wire

// File: tb/tb_gpr_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpr_wb_ctrl
// Description : Directed self-checking bench for gpr_wb_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_wb_ctrl;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset;
    logic            pipe_wb_en;
    logic [4:0]      pipe_wb_addr;
    logic [XLEN-1:0] pipe_wb_data;
    logic            lq_valid;
    logic            lq_ready;
    logic [4:0]      lq_addr;
    logic [XLEN-1:0] lq_data;
    logic            rf_wrt_en;
    logic [4:0]      rf_wrt_addr;
    logic [XLEN-1:0] rf_wrt_data;
    logic [31:0]     busy;
    logic            wb_stall_req;
`ifdef GPR_WB_FWD_EN
    logic [4:0]      rd_addr1;
    logic [4:0]      rd_addr2;
    logic [XLEN-1:0] rf_rd_data1;
    logic [XLEN-1:0] rf_rd_data2;
    logic [XLEN-1:0] fwd_data1;
    logic [XLEN-1:0] fwd_data2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    gpr_wb_ctrl #(
        .DEPTH      (4),
        .XLEN       (XLEN),
        .STARVE_MAX (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pipe_wb_en   (pipe_wb_en),
        .pipe_wb_addr (pipe_wb_addr),
        .pipe_wb_data (pipe_wb_data),
        .lq_valid     (lq_valid),
        .lq_ready     (lq_ready),
        .lq_addr      (lq_addr),
        .lq_data      (lq_data),
        .rf_wrt_en    (rf_wrt_en),
        .rf_wrt_addr  (rf_wrt_addr),
        .rf_wrt_data  (rf_wrt_data),
        .busy         (busy),
        .wb_stall_req (wb_stall_req)
`ifdef GPR_WB_FWD_EN
       ,.rd_addr1     (rd_addr1),
        .rd_addr2     (rd_addr2),
        .rf_rd_data1  (rf_rd_data1),
        .rf_rd_data2  (rf_rd_data2),
        .fwd_data1    (fwd_data1),
        .fwd_data2    (fwd_data2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic en, input logic [4:0] addr,
                            input logic [XLEN-1:0] data);
        check({tag, ".en"},   64'(rf_wrt_en),   64'(en));
        check({tag, ".addr"}, 64'(rf_wrt_addr), 64'(addr));
        check({tag, ".data"}, 64'(rf_wrt_data), 64'(data));
    endtask

    initial begin
        reset = 1'b1;
        pipe_wb_en = 1'b0; pipe_wb_addr = '0; pipe_wb_data = '0;
        lq_valid = 1'b1; lq_addr = 5'd2; lq_data = 32'h1111_0000;
`ifdef GPR_WB_FWD_EN
        rd_addr1 = '0; rd_addr2 = '0; rf_rd_data1 = '0; rf_rd_data2 = '0;
`endif
        // ---------------- reset ----------------
        #1;
        check("rst.lq_ready", 64'(lq_ready), 64'd0);
        step(); step();
        check("rst.lq_ready2", 64'(lq_ready), 64'd0);
        check_wr("rst", 1'b0, 5'd0, 32'h0);
        check("rst.busy",  64'(busy), 64'd0);
        check("rst.stall", 64'(wb_stall_req), 64'd0);
        lq_valid = 1'b0;
        reset = 1'b0;
        step();
        check("rel.lq_ready", 64'(lq_ready), 64'd1);
        check("rel.busy", 64'(busy), 64'd0);
        check("rel.en", 64'(rf_wrt_en), 64'd0);

        // ---------------- single pipeline write ----------------
        pipe_wb_en = 1'b1; pipe_wb_addr = 5'd5; pipe_wb_data = 32'hDEAD_BEEF;
        step();
        check_wr("pipe", 1'b1, 5'd5, 32'hDEAD_BEEF);
        check("pipe.busy", 64'(busy), 64'h20);
        pipe_wb_en = 1'b0;
        step();
        check_wr("pipe.hold", 1'b0, 5'd5, 32'hDEAD_BEEF);
        check("pipe.busy_clr", 64'(busy), 64'h0);

`ifdef GPR_WB_FWD_EN
        // ---------------- bypass ----------------
        pipe_wb_en = 1'b1; pipe_wb_addr = 5'd3; pipe_wb_data = 32'h0000_1234;
        step();
        pipe_wb_en = 1'b0;
        rd_addr1 = 5'd3; rf_rd_data1 = 32'h0;
        rd_addr2 = 5'd0; rf_rd_data2 = 32'hAAAA_5555;
        #1;
        check("fwd.d1", 64'(fwd_data1), 64'h1234);
        check("fwd.d2", 64'(fwd_data2), 64'hAAAA_5555);
        step();
        check("fwd.d1_idle", 64'(fwd_data1), 64'h0);
        rd_addr1 = '0; rf_rd_data2 = '0;
`endif

        // ---------------- fill queue while pipeline hogs the port ----------------
        pipe_wb_en = 1'b1; pipe_wb_addr = 5'd9; pipe_wb_data = 32'h9999_9999;
        for (int i = 1; i <= 4; i++) begin
            lq_valid = 1'b1; lq_addr = 5'(i); lq_data = 32'hA000_0000 + 32'(i);
            check($sformatf("fill.ready%0d", i), 64'(lq_ready), 64'd1);
            step();
        end
        // Entry offered while full must be refused
        lq_valid = 1'b1; lq_addr = 5'd6; lq_data = 32'h6666_6666;
        check("full.ready", 64'(lq_ready), 64'd0);
        check("full.stall_pre", 64'(wb_stall_req), 64'd0);
        check("full.busy", 64'(busy), 64'h21E);
        step();
        check("full.stall", 64'(wb_stall_req), 64'd1);
        step();
        check("full.stall_hold", 64'(wb_stall_req), 64'd1);
        check("full.busy_no6", 64'(busy), 64'h21E);
        pipe_wb_en = 1'b0; lq_valid = 1'b0;
        step();
        check_wr("drain1", 1'b1, 5'd1, 32'hA000_0001);
        check("drain1.stall", 64'(wb_stall_req), 64'd0);
        check("drain1.ready", 64'(lq_ready), 64'd1);
        check("drain1.busy", 64'(busy), 64'h1E);
        for (int i = 2; i <= 4; i++) begin
            step();
            check_wr($sformatf("drain%0d", i), 1'b1, 5'(i), 32'hA000_0000 + 32'(i));
        end
        check("drain4.busy", 64'(busy), 64'h10);
        step();
        check("drained.en", 64'(rf_wrt_en), 64'd0);
        check("drained.busy", 64'(busy), 64'h0);

        // ---------------- writes to x0 ----------------
        pipe_wb_en = 1'b1; pipe_wb_addr = 5'd0; pipe_wb_data = 32'hFFFF_FFFF;
        lq_valid = 1'b1; lq_addr = 5'd0; lq_data = 32'hEEEE_EEEE;
        check("x0.ready", 64'(lq_ready), 64'd1);
        step();
        pipe_wb_en = 1'b0; lq_valid = 1'b0;
        check("x0.en", 64'(rf_wrt_en), 64'd0);
        check("x0.busy", 64'(busy), 64'h0);
        step();
        check("x0.en2", 64'(rf_wrt_en), 64'd0);
        check("x0.busy2", 64'(busy), 64'h0);

        // ---------------- simultaneous push and pop at count=2 ----------------
        pipe_wb_en = 1'b1; pipe_wb_addr = 5'd12; pipe_wb_data = 32'hC0C0_C0C0;
        lq_valid = 1'b1; lq_addr = 5'd10; lq_data = 32'h1010_1010;
        step();
        lq_addr = 5'd11; lq_data = 32'h1111_1111;
        step();
        check("pp.busy_pre", 64'(busy), 64'h1C00);
        pipe_wb_en = 1'b0;
        lq_addr = 5'd7; lq_data = 32'h7777_7777;
        step();
        lq_valid = 1'b0;
        check_wr("pp.w10", 1'b1, 5'd10, 32'h1010_1010);
        check("pp.busy10", 64'(busy), 64'hC80);
        step();
        check_wr("pp.w11", 1'b1, 5'd11, 32'h1111_1111);
        check("pp.busy11", 64'(busy), 64'h880);
        step();
        check_wr("pp.w7", 1'b1, 5'd7, 32'h7777_7777);
        check("pp.busy7", 64'(busy), 64'h80);
        step();
        check("pp.en_done", 64'(rf_wrt_en), 64'd0);
        check("pp.busy_done", 64'(busy), 64'h0);

        // ---------------- reset mid-operation ----------------
        pipe_wb_en = 1'b1; pipe_wb_addr = 5'd8; pipe_wb_data = 32'h8888_8888;
        lq_valid = 1'b1; lq_addr = 5'd13; lq_data = 32'h1313_1313;
        step();
        pipe_wb_en = 1'b0; lq_valid = 1'b0;
        check("mid.busy_pre", 64'(busy), 64'h2100);
        reset = 1'b1;
        #1;
        check("mid.busy_rst", 64'(busy), 64'h0);
        check("mid.en_rst", 64'(rf_wrt_en), 64'd0);
        check("mid.ready_rst", 64'(lq_ready), 64'd0);
        step();
        reset = 1'b0;
        step();
        check("mid.en_after", 64'(rf_wrt_en), 64'd0);
        check("mid.busy_after", 64'(busy), 64'h0);
        check("mid.stall_after", 64'(wb_stall_req), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_gpr_wb_ctrl
`default_nettype wire
